wb_ddr_arbiter: RTL and testbench

WB_DDR_ARBITER -- requirements
Module: wb_ddr_arbiter

---
 rtl/wb_ddr_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_ddr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ddr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_ddr_arbiter
// Description : Two-master Wishbone arbiter in front of the DDR wrapper slave,
//               with locked bursts, alternating priority and wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ddr_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         cpu_clk,
  input  logic         rst,
  input  logic         m0_cyc_i,
  input  logic         m0_stb_i,
  input  logic         m0_we_i,
  input  logic [2:31]  m0_adr_i,
  input  logic [0:31]  m0_dat_i,
  input  logic [0:3]   m0_sel_i,
  output logic [0:31]  m0_dat_o,
  output logic         m0_ack_o,
  output logic         m0_err_o,
  input  logic         m1_cyc_i,
  input  logic         m1_stb_i,
  input  logic         m1_we_i,
  input  logic [2:31]  m1_adr_i,
  input  logic [0:31]  m1_dat_i,
  input  logic [0:3]   m1_sel_i,
  output logic [0:31]  m1_dat_o,
  output logic         m1_ack_o,
  output logic         m1_err_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  output logic         s_we_o,
  output logic [2:31]  s_adr_o,
  output logic [0:31]  s_dat_o,
  output logic [0:3]   s_sel_o,
  input  logic [0:31]  s_dat_i,
  input  logic         s_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUS_M0 = 2'd1,
    S_BUS_M1 = 2'd2,
    S_ABORT  = 2'd3
  } state_t;

  localparam logic [15:0] c_wait_last = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_last_grant;
  logic [15:0] r_wait_cnt;

  logic w_req0, w_req1, w_bus0, w_bus1, w_abort, w_stall, w_timeout;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;

  // Reset gates the decode so every output already reads 0 while rst is high.
  assign w_bus0  = (r_state == S_BUS_M0) & ~rst;
  assign w_bus1  = (r_state == S_BUS_M1) & ~rst;
  assign w_abort = (r_state == S_ABORT)  & ~rst;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (w_bus0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      m0_ack_o = s_ack_i & m0_stb_i;
      m0_dat_o = s_dat_i;
    end else if (w_bus1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      m1_ack_o = s_ack_i & m1_stb_i;
      m1_dat_o = s_dat_i;
    end
    if (w_abort) begin
      m0_err_o = ~r_last_grant;
      m1_err_o = r_last_grant;
    end
  end

  assign w_stall   = s_stb_o & ~s_ack_i;
  assign w_timeout = w_stall & (r_wait_cnt == c_wait_last);

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= '0;
    end else begin
      r_wait_cnt <= w_stall ? r_wait_cnt + 16'd1 : 16'd0;
      case (r_state)
        S_IDLE: begin
          // On contention the master that did not win last time goes first.
          if (w_req0 & (~w_req1 | r_last_grant)) begin
            r_state      <= S_BUS_M0;
            r_last_grant <= 1'b0;
          end else if (w_req1) begin
            r_state      <= S_BUS_M1;
            r_last_grant <= 1'b1;
          end
        end
        S_BUS_M0: begin
          if (!m0_cyc_i)      r_state <= S_IDLE;
          else if (w_timeout) r_state <= S_ABORT;
        end
        S_BUS_M1: begin
          if (!m1_cyc_i)      r_state <= S_IDLE;
          else if (w_timeout) r_state <= S_ABORT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_ddr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ddr_arbiter
// Description : Directed bench for wb_ddr_arbiter with a cycle-level
//               ownership model and hand-computed spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ddr_arbiter;

  localparam int TMO = 8;

  logic        cpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [2:31] m0_adr_i = '0;
  logic [0:31] m0_dat_i = '0;
  logic [0:3]  m0_sel_i = '0;
  logic [0:31] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [2:31] m1_adr_i = '0;
  logic [0:31] m1_dat_i = '0;
  logic [0:3]  m1_sel_i = '0;
  logic [0:31] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [2:31] s_adr_o;
  logic [0:31] s_dat_o;
  logic [0:3]  s_sel_o;
  logic [0:31] s_dat_i = '0;
  logic        s_ack_i = 1'b0;

  wb_ddr_arbiter #(.TIMEOUT(TMO)) dut (
    .cpu_clk(cpu_clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the slave (-1 = nobody), whether an abort cycle is due,
  // who was granted last, and how long the current strobe has waited.
  int owner = -1;
  bit aborting = 0;
  int last = 1;
  int waited = 0;

  always @(posedge cpu_clk) begin
    bit stb_now, cyc_now, stalled, r0, r1;
    if (rst) begin
      owner = -1; aborting = 0; last = 1; waited = 0;
    end else begin
      stb_now = (owner == 0) ? m0_stb_i : (owner == 1) ? m1_stb_i : 1'b0;
      cyc_now = (owner == 0) ? m0_cyc_i : (owner == 1) ? m1_cyc_i : 1'b0;
      stalled = stb_now && !s_ack_i;
      r0 = m0_cyc_i && m0_stb_i;
      r1 = m1_cyc_i && m1_stb_i;
      if (aborting) aborting = 0;
      else if (owner < 0) begin
        if (r0 && r1) owner = 1 - last;
        else if (r0)  owner = 0;
        else if (r1)  owner = 1;
        if (owner >= 0) last = owner;
      end else if (!cyc_now) owner = -1;
      else if (stalled && waited == TMO - 1) begin
        owner = -1; aborting = 1;
      end
      waited = stalled ? waited + 1 : 0;
    end
  end

  logic        e_cyc, e_stb, e_we, e_ack0, e_ack1, e_err0, e_err1;
  logic [2:31] e_adr;
  logic [0:31] e_dat, e_rd0, e_rd1;
  logic [0:3]  e_sel;
  bit          rec_grants = 0;
  bit          prev_scyc = 0;
  int          grant_q[$];

  always @(negedge cpu_clk) begin
    e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
    e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_rd0 = '0; e_rd1 = '0;
    if (!rst) begin
      if (owner == 0) begin
        e_cyc = m0_cyc_i; e_stb = m0_stb_i; e_we = m0_we_i;
        e_adr = m0_adr_i; e_dat = m0_dat_i; e_sel = m0_sel_i;
        e_ack0 = s_ack_i & m0_stb_i; e_rd0 = s_dat_i;
      end else if (owner == 1) begin
        e_cyc = m1_cyc_i; e_stb = m1_stb_i; e_we = m1_we_i;
        e_adr = m1_adr_i; e_dat = m1_dat_i; e_sel = m1_sel_i;
        e_ack1 = s_ack_i & m1_stb_i; e_rd1 = s_dat_i;
      end
      if (aborting) begin
        if (last == 0) e_err0 = 1; else e_err1 = 1;
      end
    end
    check("s_cyc_o",  32'(s_cyc_o),  32'(e_cyc));
    check("s_stb_o",  32'(s_stb_o),  32'(e_stb));
    check("s_we_o",   32'(s_we_o),   32'(e_we));
    check("s_adr_o",  32'(s_adr_o),  32'(e_adr));
    check("s_dat_o",  s_dat_o,       e_dat);
    check("s_sel_o",  32'(s_sel_o),  32'(e_sel));
    check("m0_ack_o", 32'(m0_ack_o), 32'(e_ack0));
    check("m1_ack_o", 32'(m1_ack_o), 32'(e_ack1));
    check("m0_err_o", 32'(m0_err_o), 32'(e_err0));
    check("m1_err_o", 32'(m1_err_o), 32'(e_err1));
    check("m0_dat_o", m0_dat_o,      e_rd0);
    check("m1_dat_o", m1_dat_o,      e_rd1);
    if (rec_grants && s_cyc_o && !prev_scyc) grant_q.push_back((s_adr_o == 30'h20) ? 1 : 0);
    prev_scyc = s_cyc_o;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge cpu_clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic v);
    if (m == 0) begin m0_cyc_i = v; m0_stb_i = v; end
    else        begin m1_cyc_i = v; m1_stb_i = v; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n_stb;
    bit got_err;
    int exp_alt[4];
    exp_alt = '{0, 1, 0, 1};

    // Both masters request while reset is held: nothing may reach the slave.
    m0_we_i = 0; m0_adr_i = 30'h10; m0_sel_i = 4'hF;
    m1_we_i = 1; m1_adr_i = 30'h100; m1_sel_i = 4'b0011; m1_dat_i = 32'hCAFE_0001;
    set_req(0, 1); set_req(1, 1); s_ack_i = 1;
    tick(3);
    #2;
    check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    check("rst_m0_ack", 32'(m0_ack_o), 32'd0);
    s_ack_i = 0;

    // Contention right after reset: master 0 first, read returns DEADBEEF.
    @(negedge cpu_clk); #2; rst = 0;
    tick();
    s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
    #2;
    check("first_m0_ack", 32'(m0_ack_o), 32'd1);
    check("first_m0_dat", m0_dat_o, 32'hDEADBEEF);
    check("first_m1_ack", 32'(m1_ack_o), 32'd0);
    check("first_adr", 32'(s_adr_o), 32'h10);

    // Master 0 releases, master 1 waits: one idle cycle, then master 1.
    tick(); s_ack_i = 0; set_req(0, 0);
    #2; check("release_scyc", 32'(s_cyc_o), 32'd0);
    tick();
    #2; check("idle_scyc", 32'(s_cyc_o), 32'd0);
    tick(); s_ack_i = 1;
    #2;
    check("m1_scyc", 32'(s_cyc_o), 32'd1);
    check("m1_adr", 32'(s_adr_o), 32'h100);
    check("m1_sel", 32'(s_sel_o), 32'h3);
    check("m1_we", 32'(s_we_o), 32'd1);
    check("m1_wdat", s_dat_o, 32'hCAFE_0001);
    check("m1_ack", 32'(m1_ack_o), 32'd1);
    tick(); s_ack_i = 0; set_req(1, 0);
    tick(2);

    // Alternating single-cycle grants under continuous contention.
    m1_we_i = 0; m1_adr_i = 30'h20;
    grant_q.delete(); rec_grants = 1;
    set_req(0, 1); set_req(1, 1);
    for (int i = 0; i < 4; i++) begin
      g = -1;
      for (int k = 0; k < 10; k++) begin
        #1;
        if (s_cyc_o) begin g = (s_adr_o == 30'h20) ? 1 : 0; break; end
        tick();
      end
      if (g < 0) begin check("alt_grant_wait", 32'd0, 32'd1); break; end
      s_ack_i = 1;
      tick(); s_ack_i = 0;
      if (i == 3) begin set_req(0, 0); set_req(1, 0); end
      else set_req(g, 0);
      tick();
      if (i < 3) set_req(g, 1);
    end
    tick(2); rec_grants = 0;
    check("alt_count", 32'(grant_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check("alt_order", 32'(grant_q[i]), 32'(exp_alt[i]));

    // Locked 4-beat burst on master 0 starves master 1.
    m0_adr_i = 30'h10;
    set_req(0, 1); set_req(1, 1);
    tick(); s_ack_i = 1;
    for (int b = 0; b < 4; b++) begin
      m0_adr_i = 30'h40 + 30'(b);
      #2;
      check("burst_adr", 32'(s_adr_o), 32'h40 + 32'(b));
      check("burst_m1_ack", 32'(m1_ack_o), 32'd0);
      tick();
    end
    s_ack_i = 0; set_req(0, 0);
    #2; check("burst_drop", 32'(s_cyc_o), 32'd0);
    tick(2);
    #2;
    check("burst_m1_cyc", 32'(s_cyc_o), 32'd1);
    check("burst_m1_adr", 32'(s_adr_o), 32'h20);
    s_ack_i = 1; tick(); s_ack_i = 0; set_req(1, 0);
    tick(2);

    // Slave never acks: 8 waiting strobes, then one error cycle.
    m0_adr_i = 30'h50; set_req(0, 1);
    n_stb = 0; got_err = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); #1;
      if (m0_err_o) begin got_err = 1; break; end
      if (s_stb_o) n_stb++;
    end
    check("tmo_err_seen", 32'(got_err), 32'd1);
    check("tmo_strobes", 32'(n_stb), 32'd8);
    check("tmo_abort_scyc", 32'(s_cyc_o), 32'd0);
    check("tmo_m1_err", 32'(m1_err_o), 32'd0);
    set_req(1, 1);
    tick(); #1;
    check("tmo_err_once", 32'(m0_err_o), 32'd0);
    check("tmo_idle_scyc", 32'(s_cyc_o), 32'd0);
    tick(); #1;
    check("tmo_rearb_m1", 32'(s_adr_o), 32'h20);
    s_ack_i = 1; tick(); s_ack_i = 0; set_req(0, 0); set_req(1, 0);
    tick(2);

    // Ack on the 8th wait cycle wins over the timeout.
    m0_adr_i = 30'h60; set_req(0, 1);
    tick(8);
    s_ack_i = 1; #1;
    check("late_ack", 32'(m0_ack_o), 32'd1);
    check("late_no_err", 32'(m0_err_o), 32'd0);
    tick(); s_ack_i = 0;
    tick(3); set_req(1, 1);
    tick();
    // Reset mid-burst abandons the transfer silently.
    rst = 1; s_ack_i = 1; #1;
    check("rst_mid_scyc", 32'(s_cyc_o), 32'd0);
    check("rst_mid_ack", 32'(m0_ack_o), 32'd0);
    tick(); #1;
    check("rst_after_scyc", 32'(s_cyc_o), 32'd0);
    check("rst_after_err", 32'(m0_err_o), 32'd0);
    rst = 0; s_ack_i = 0;
    tick(); #1;
    check("rst_first_grant", 32'(s_adr_o), 32'h60);
    set_req(0, 0); set_req(1, 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
